puf_response_collector: RTL and testbench

PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

---
 rtl/puf_response_collector.sv | 97 +++++++++
 tb/tb_puf_response_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_collector.sv
// Sequences ring-oscillator challenges through an arbiter and assembles the PUF response, one bit per challenge.
// Per bit: CLR_CYCLES clear cycles, then RUN until arb_finish or TIMEOUT. start is only accepted in IDLE.
module puf_response_collector #(
  parameter int N_BITS     = 8,
  parameter int CHAL_W     = 3,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              arb_resp,
  input  logic              arb_finish,
  output logic [CHAL_W-1:0] chal,
  output logic              ro_en,
  output logic              arb_rst,
  output logic [N_BITS-1:0] response,
  output logic              valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + CLR_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CLR_LAST  = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CHAL_W-1:0] CHAL_LAST = CHAL_W'(N_BITS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CHAL_W-1:0]  r_chal;
  logic [N_BITS-1:0]  r_resp;
  logic               r_err;
  logic               w_capture;
  logic               w_bit;

  // A finishing arbiter beats the timeout on the same edge.
  assign w_capture = arb_finish || (r_cnt == TO_LAST);
  assign w_bit     = arb_finish & arb_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_chal  <= '0;
      r_resp  <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_chal  <= '0;
            r_resp  <= '0;
            r_err   <= 1'b0;
          end
        end
        CLEAR: begin
          if (r_cnt == CLR_LAST) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (w_capture) begin
            r_resp[r_chal] <= w_bit;
            if (!arb_finish) r_err <= 1'b1;
            r_cnt <= '0;
            if (r_chal == CHAL_LAST) begin
              r_state <= DONE;
            end else begin
              r_chal  <= r_chal + 1'b1;
              r_state <= CLEAR;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign chal        = r_chal;
  assign response    = r_resp;
  assign timeout_err = r_err;
  assign ro_en       = (r_state == RUN);
  assign arb_rst     = (r_state == IDLE) || (r_state == CLEAR);
  assign valid       = (r_state == DONE);
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_puf_response_collector.sv
// Randomized bench for puf_response_collector: a per-challenge arbiter plan drives the DUT and
// the expected response, error flag, run lengths and latency are computed from that plan.
module tb_puf_response_collector;
  localparam int N_BITS     = 8;
  localparam int CHAL_W     = 3;
  localparam int CLR_CYCLES = 2;
  localparam int TIMEOUT    = 255;

  logic              clk = 1'b0;
  logic              rst, start, arb_resp, arb_finish;
  logic [CHAL_W-1:0] chal;
  logic              ro_en, arb_rst, valid, busy, timeout_err;
  logic [N_BITS-1:0] response;

  int n_checks = 0;
  int n_fail   = 0;
  // plan_d[k]: RUN cycle index (0-based) where arb_finish rises for challenge k; -1 = never
  int   plan_d[N_BITS];
  logic plan_r[N_BITS];

  puf_response_collector #(
    .N_BITS(N_BITS), .CHAL_W(CHAL_W), .CLR_CYCLES(CLR_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .arb_resp(arb_resp), .arb_finish(arb_finish),
    .chal(chal), .ro_en(ro_en), .arb_rst(arb_rst), .response(response),
    .valid(valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_chal"}, chal, 0);
    chk({tag, "_ro_en"}, ro_en, 0);
    chk({tag, "_arb_rst"}, arb_rst, 1);
    chk({tag, "_response"}, response, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic run_test(input bit hold_start, input int abort_chal);
    logic [N_BITS-1:0] exp_resp;
    logic [N_BITS-1:0] mask;
    bit exp_err;
    int exp_lat, exp_len;
    int run_len[N_BITS];
    int cyc, rc, cc, nvalid, vcyc;
    bit done, aborted;
    exp_resp = '0; exp_err = 0; exp_lat = 0;
    for (int k = 0; k < N_BITS; k++) begin
      run_len[k] = 0;
      if (plan_d[k] >= 0 && plan_d[k] < TIMEOUT) begin
        exp_resp[k] = plan_r[k];
        exp_lat += CLR_CYCLES + plan_d[k] + 1;
      end else begin
        exp_err = 1;
        exp_lat += CLR_CYCLES + TIMEOUT;
      end
    end
    @(negedge clk);
    start = 1'b1;
    cyc = 0; rc = 0; cc = 0; nvalid = 0; vcyc = -1; done = 0; aborted = 0;
    while (!done && !aborted && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = 1'b0;
      arb_finish = 1'($urandom_range(0, 1));
      arb_resp   = 1'($urandom_range(0, 1));
      if (valid) begin
        nvalid++;
        vcyc = cyc;
        done = 1;
      end
      if (ro_en) begin
        if (rc == 0) begin
          chk("clear_len", cc, CLR_CYCLES);
          mask = N_BITS'((1 << chal) - 1);
          chk("partial_resp", response, exp_resp & mask);
          chk("busy_run", busy, 1);
        end
        cc = 0;
        if (abort_chal == int'(chal) && rc == 1) begin
          rst = 1'b1;
          #1 chk_reset_vals("abort");
          aborted = 1;
        end else begin
          arb_finish = (plan_d[chal] == rc);
          if (arb_finish) arb_resp = plan_r[chal];
          rc++;
          run_len[chal] = rc;
        end
      end else begin
        rc = 0;
        if (busy && arb_rst) cc++;
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      arb_finish = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (valid) nvalid++;
      end
      chk("abort_no_valid", nvalid, 0);
      chk("abort_idle", busy, 0);
      return;
    end
    chk("wait_valid", done, 1);
    chk("latency", vcyc - 1, exp_lat);
    chk("response", response, exp_resp);
    chk("timeout_err", timeout_err, exp_err);
    for (int k = 0; k < N_BITS; k++) begin
      exp_len = (plan_d[k] >= 0 && plan_d[k] < TIMEOUT) ? plan_d[k] + 1 : TIMEOUT;
      chk($sformatf("run_len%0d", k), run_len[k], exp_len);
    end
    @(negedge clk);
    arb_finish = 1'b0;
    if (valid) nvalid++;
    chk("valid_pulses", nvalid, 1);
    chk("idle_after_done", busy, 0);
    chk("hold_response", response, exp_resp);
    chk("hold_err", timeout_err, exp_err);
    if (hold_start) begin
      @(negedge clk);
      chk("restart_busy", busy, 1);
      chk("restart_chal", chal, 0);
      chk("restart_resp", response, 0);
      start = 1'b0;
      rst = 1'b1;
      #1 chk_reset_vals("clear_restart");
      @(negedge clk);
      rst = 1'b0;
    end else begin
      repeat (3) @(negedge clk);
      chk("held_response", response, exp_resp);
      chk("held_err", timeout_err, exp_err);
      chk("held_valid", valid, 0);
    end
  endtask

  task automatic plan_fixed(input int d, input logic [N_BITS-1:0] bits);
    for (int k = 0; k < N_BITS; k++) begin
      plan_d[k] = d;
      plan_r[k] = bits[k];
    end
  endtask

  task automatic plan_random();
    for (int k = 0; k < N_BITS; k++) begin
      case ($urandom_range(0, 9))
        0:       plan_d[k] = -1;
        1:       plan_d[k] = TIMEOUT - 1;
        default: plan_d[k] = int'($urandom_range(0, 12));
      endcase
      plan_r[k] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [N_BITS-1:0] nominal;
    rst = 1'b1; start = 1'b0; arb_finish = 1'b0; arb_resp = 1'b0;
    #1 chk_reset_vals("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    nominal = 8'b0100_1101;
    plan_fixed(3, nominal);
    run_test(0, -1);
    chk("nominal_4d", response, 8'h4D);

    plan_fixed(0, 8'hA5);
    run_test(0, -1);

    plan_fixed(3, nominal);
    plan_d[2] = -1;
    plan_r[2] = 1'b1;
    run_test(0, -1);

    plan_fixed(1, 8'h3C);
    plan_d[3] = TIMEOUT - 1;
    plan_r[3] = 1'b1;
    run_test(0, -1);

    plan_random();
    run_test(0, 5);
    plan_fixed(0, 8'hFF);
    run_test(0, -1);

    plan_random();
    run_test(1, -1);

    for (int i = 0; i < 6; i++) begin
      plan_random();
      run_test(0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
